// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Handles one fetch at a time, with miss refill from memory and flush on misbranch.
module inst_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        has_misbranch,
  input  logic        in_fetch_valid,
  input  logic [31:0] in_fetch_pc,
  output logic        out_inst_ready,
  output logic [31:0] out_inst,
  output logic        out_mem_ask,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_ready,
  input  logic [31:0] in_mem_inst
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic {
    IDLE,
    MISS_WAIT
  } state_t;

  state_t state;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill;
  logic                  unused_pc_bits;

  assign req_index  = in_fetch_pc[INDEX_BITS+1:2];
  assign req_tag    = in_fetch_pc[31:2+INDEX_BITS];
  assign fill_index = out_mem_addr[INDEX_BITS+1:2];
  assign fill_tag   = out_mem_addr[31:2+INDEX_BITS];
  assign hit        = valid[req_index] && (tags[req_index] == req_tag);
  assign unused_pc_bits = ^{in_fetch_pc[1:0], out_mem_addr[1:0]};

  // Fill still happens on a flush that coincides with the memory reply.
  assign fill = rdy && !rst && (state == MISS_WAIT) && in_mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      valid          <= '0;
      out_inst_ready <= 1'b0;
      out_mem_ask    <= 1'b0;
      out_inst       <= '0;
      out_mem_addr   <= '0;
    end else if (rdy) begin
      out_inst_ready <= 1'b0;
      out_mem_ask    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_fetch_valid && !has_misbranch) begin
            if (hit) begin
              out_inst_ready <= 1'b1;
              out_inst       <= data[req_index];
            end else begin
              out_mem_ask  <= 1'b1;
              out_mem_addr <= {in_fetch_pc[31:2], 2'b00};
              state        <= MISS_WAIT;
            end
          end
        end
        MISS_WAIT: begin
          if (in_mem_ready) begin
            valid[fill_index] <= 1'b1;
            state             <= IDLE;
            if (!has_misbranch) begin
              out_inst_ready <= 1'b1;
              out_inst       <= in_mem_inst;
            end
          end else if (has_misbranch) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits gate every hit.
  always_ff @(posedge clk) begin
    if (fill) begin
      data[fill_index] <= in_mem_inst;
      tags[fill_index] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus random fetches
// against a line-address reference model.
module tb_inst_cache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        has_misbranch;
  logic        in_fetch_valid;
  logic [31:0] in_fetch_pc;
  logic        out_inst_ready;
  logic [31:0] out_inst;
  logic        out_mem_ask;
  logic [31:0] out_mem_addr;
  logic        in_mem_ready;
  logic [31:0] in_mem_inst;

  int errors = 0;
  int checks = 0;

  bit          mvalid [64];
  logic [31:0] maddr  [64];
  logic [31:0] mdata  [64];

  inst_cache #(.INDEX_BITS(6)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .has_misbranch(has_misbranch),
    .in_fetch_valid(in_fetch_valid),
    .in_fetch_pc(in_fetch_pc),
    .out_inst_ready(out_inst_ready),
    .out_inst(out_inst),
    .out_mem_ask(out_mem_ask),
    .out_mem_addr(out_mem_addr),
    .in_mem_ready(in_mem_ready),
    .in_mem_inst(in_mem_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  function automatic bit model_hit(input logic [31:0] pc);
    int i;
    i = int'(pc[7:2]);
    return mvalid[i] && (maddr[i] == {pc[31:2], 2'b00});
  endfunction

  task automatic model_fill(input logic [31:0] addr, input logic [31:0] w);
    int i;
    i = int'(addr[7:2]);
    mvalid[i] = 1'b1;
    maddr[i]  = {addr[31:2], 2'b00};
    mdata[i]  = w;
  endtask

  // Full fetch transaction; on a miss the memory replies lat cycles after the ask.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] w,
                       input int lat);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    in_fetch_valid = 1'b1;
    in_fetch_pc    = pc;
    step();
    in_fetch_valid = 1'b0;
    in_fetch_pc    = $urandom;
    if (model_hit(pc)) begin
      chk("hit_ready", {31'd0, out_inst_ready}, 32'd1);
      chk("hit_inst", out_inst, mdata[int'(pc[7:2])]);
      chk("hit_no_ask", {31'd0, out_mem_ask}, 32'd0);
    end else begin
      chk("miss_ask", {31'd0, out_mem_ask}, 32'd1);
      chk("miss_addr", out_mem_addr, a);
      chk("miss_no_ready", {31'd0, out_inst_ready}, 32'd0);
      for (int k = 1; k < lat; k++) begin
        step();
        chk("ask_pulse", {31'd0, out_mem_ask}, 32'd0);
        chk("addr_stable", out_mem_addr, a);
      end
      in_mem_ready = 1'b1;
      in_mem_inst  = w;
      step();
      in_mem_ready = 1'b0;
      chk("fill_ready", {31'd0, out_inst_ready}, 32'd1);
      chk("fill_inst", out_inst, w);
      chk("fill_no_ask", {31'd0, out_mem_ask}, 32'd0);
      model_fill(a, w);
    end
    step();
    chk("ready_pulse", {31'd0, out_inst_ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1;
    rdy = 1'b1;
    has_misbranch  = 1'b0;
    in_fetch_valid = 1'b0;
    in_fetch_pc    = '0;
    in_mem_ready   = 1'b0;
    in_mem_inst    = '0;
    model_clear();
    step();
    step();
    chk("rst_ready", {31'd0, out_inst_ready}, 32'd0);
    chk("rst_ask", {31'd0, out_mem_ask}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", out_mem_addr, 32'd0);
    rst = 1'b0;
    step();

    // Cold miss, hit, conflict eviction
    fetch(32'h0000_0100, 32'h0000_0013, 3);
    fetch(32'h0000_0100, 32'hDEAD_BEEF, 3);
    fetch(32'h0000_0200, 32'h1111_2222, 2);
    fetch(32'h0000_0101, 32'h0000_0013, 1);
    fetch(32'h0000_0202, 32'h3333_4444, 4);

    // Stray memory reply in IDLE is ignored
    in_mem_ready = 1'b1;
    in_mem_inst  = 32'hBAD0_0001;
    step();
    in_mem_ready = 1'b0;
    chk("idle_memrdy", {31'd0, out_inst_ready}, 32'd0);

    // Flush in MISS_WAIT, reply afterwards: no fill
    in_fetch_valid = 1'b1;
    in_fetch_pc    = 32'h0000_0300;
    step();
    in_fetch_valid = 1'b0;
    chk("fl1_ask", {31'd0, out_mem_ask}, 32'd1);
    has_misbranch = 1'b1;
    step();
    has_misbranch = 1'b0;
    chk("fl1_ready", {31'd0, out_inst_ready}, 32'd0);
    chk("fl1_ask0", {31'd0, out_mem_ask}, 32'd0);
    in_mem_ready = 1'b1;
    in_mem_inst  = 32'h5555_0300;
    step();
    in_mem_ready = 1'b0;
    chk("fl1_late", {31'd0, out_inst_ready}, 32'd0);
    fetch(32'h0000_0300, 32'h6666_0300, 2);

    // Flush coincident with reply: fill but no ready
    in_fetch_valid = 1'b1;
    in_fetch_pc    = 32'h0000_0400;
    step();
    in_fetch_valid = 1'b0;
    chk("fl2_ask", {31'd0, out_mem_ask}, 32'd1);
    has_misbranch = 1'b1;
    in_mem_ready  = 1'b1;
    in_mem_inst   = 32'h7777_0400;
    step();
    has_misbranch = 1'b0;
    in_mem_ready  = 1'b0;
    chk("fl2_ready", {31'd0, out_inst_ready}, 32'd0);
    model_fill(32'h0000_0400, 32'h7777_0400);
    fetch(32'h0000_0400, 32'h0, 1);

    // Flush with a request discards it
    in_fetch_valid = 1'b1;
    in_fetch_pc    = 32'h0000_0504;
    has_misbranch  = 1'b1;
    step();
    in_fetch_valid = 1'b0;
    has_misbranch  = 1'b0;
    chk("fl3_ask", {31'd0, out_mem_ask}, 32'd0);
    chk("fl3_ready", {31'd0, out_inst_ready}, 32'd0);
    fetch(32'h0000_0504, 32'h8888_0504, 2);

    // rdy low for 5 cycles in MISS_WAIT with reply held
    in_fetch_valid = 1'b1;
    in_fetch_pc    = 32'h0000_0608;
    step();
    in_fetch_valid = 1'b0;
    chk("rdy_ask", {31'd0, out_mem_ask}, 32'd1);
    rdy          = 1'b0;
    in_mem_ready = 1'b1;
    in_mem_inst  = 32'h9999_0608;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rdy_hold_ask", {31'd0, out_mem_ask}, 32'd1);
      chk("rdy_hold_ready", {31'd0, out_inst_ready}, 32'd0);
    end
    rdy = 1'b1;
    step();
    in_mem_ready = 1'b0;
    chk("rdy_fill_ready", {31'd0, out_inst_ready}, 32'd1);
    chk("rdy_fill_inst", out_inst, 32'h9999_0608);
    chk("rdy_fill_ask", {31'd0, out_mem_ask}, 32'd0);
    model_fill(32'h0000_0608, 32'h9999_0608);
    step();
    fetch(32'h0000_0608, 32'h0, 1);

    // Async reset mid-miss
    in_fetch_valid = 1'b1;
    in_fetch_pc    = 32'h0000_070C;
    step();
    in_fetch_valid = 1'b0;
    chk("arst_ask", {31'd0, out_mem_ask}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ask0", {31'd0, out_mem_ask}, 32'd0);
    chk("arst_addr0", out_mem_addr, 32'd0);
    chk("arst_inst0", out_inst, 32'd0);
    model_clear();
    step();
    rst = 1'b0;
    in_mem_ready = 1'b1;
    in_mem_inst  = 32'hAAAA_070C;
    step();
    in_mem_ready = 1'b0;
    chk("arst_ignore", {31'd0, out_inst_ready}, 32'd0);
    fetch(32'h0000_0100, 32'h0000_0013, 2);

    // Random fetches over a few conflicting tags
    for (int n = 0; n < 60; n++) begin
      pc = (32'($urandom_range(0, 2)) << 8) |
           (32'($urandom_range(0, 7)) << 2) |
           32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        in_mem_ready = 1'b1;
        in_mem_inst  = $urandom;
        step();
        in_mem_ready = 1'b0;
        chk("rnd_idle_memrdy", {31'd0, out_inst_ready}, 32'd0);
      end
      fetch(pc, $urandom, int'($urandom_range(1, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
